// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-shift helpers for the AXI Stream header extractor.
package axis_hdr_pkg;

    localparam int unsigned DEF_DATA_WD = 32;
    localparam int unsigned MAX_DATA_WD = 512;
    localparam int unsigned MAX_BYTE_WD = MAX_DATA_WD / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAD  = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Data and keep travel together so one shift moves both consistently.
    typedef struct packed {
        logic [MAX_DATA_WD-1:0] data;
        logic [MAX_BYTE_WD-1:0] keep;
    } wide_beat_t;

    function automatic wide_beat_t byte_shift_l(input wide_beat_t b, input int unsigned n);
        wide_beat_t r;
        r.data = b.data << (8 * n);
        r.keep = b.keep << n;
        return r;
    endfunction

    function automatic wide_beat_t byte_shift_r(input wide_beat_t b, input int unsigned n);
        wide_beat_t r;
        r.data = b.data >> (8 * n);
        r.keep = b.keep >> n;
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_BYTE_WD-1:0] k);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_BYTE_WD; i++) begin
            c = c + 32'(k[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Splits an input beat at the header boundary: right-shifted part (header or
// merge tail) and left-shifted part (next residual), merged with the old residual.
module axis_byte_merge
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = DEF_DATA_WD,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_WD-1:0]      res_data,
    input  logic [DATA_BYTE_WD-1:0] res_keep,
    input  logic [DATA_WD-1:0]      data,
    input  logic [DATA_BYTE_WD-1:0] keep,
    input  logic [LEN_WD-1:0]       hdr_len,
    output logic [DATA_WD-1:0]      shr_data_c,
    output logic [DATA_BYTE_WD-1:0] shr_keep_c,
    output logic [DATA_WD-1:0]      merge_data_c,
    output logic [DATA_BYTE_WD-1:0] merge_keep_c,
    output logic [DATA_WD-1:0]      next_data_c,
    output logic [DATA_BYTE_WD-1:0] next_keep_c
);

    logic [DATA_WD-1:0] masked;
    wide_beat_t         in_w;
    wide_beat_t         shr;
    wide_beat_t         shl;

    // Lanes without keep are zeroed before shifting so they never leak out.
    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            masked[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
        end
        in_w      = '0;
        in_w.data = MAX_DATA_WD'(masked);
        in_w.keep = MAX_BYTE_WD'(keep);
        shr       = byte_shift_r(in_w, DATA_BYTE_WD - 32'(hdr_len));
        shl       = byte_shift_l(in_w, 32'(hdr_len));

        shr_data_c   = DATA_WD'(shr.data);
        shr_keep_c   = DATA_BYTE_WD'(shr.keep);
        merge_data_c = res_data | shr_data_c;
        merge_keep_c = res_keep | shr_keep_c;
        next_data_c  = DATA_WD'(shl.data);
        next_keep_c  = DATA_BYTE_WD'(shl.keep);
    end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..W byte header from each packet onto a header channel and realigns the payload.
// Optional AXIS_EXTRACT_SHORT_ERR_EN adds err_header for a short first beat.
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = DEF_DATA_WD,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_extract,
    input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
    output logic                    ready_extract,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
    output logic                    err_header,
`endif
    input  logic                    ready_header,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    localparam int unsigned LEN_WD = BYTE_CNT_WD + 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [LEN_WD-1:0]       hdr_len;
    logic [DATA_WD-1:0]      res_data;
    logic [DATA_BYTE_WD-1:0] res_keep;

    logic [DATA_WD-1:0]      shr_data_c;
    logic [DATA_BYTE_WD-1:0] shr_keep_c;
    logic [DATA_WD-1:0]      merge_data_c;
    logic [DATA_BYTE_WD-1:0] merge_keep_c;
    logic [DATA_WD-1:0]      next_data_c;
    logic [DATA_BYTE_WD-1:0] next_keep_c;

    logic out_free_c;
    logic hdr_free_c;
    logic cmd_fire_c;
    logic in_fire_c;
    logic next_res_nz_c;

    assign out_free_c    = ~valid_out | ready_out;
    assign hdr_free_c    = ~valid_header | ready_header;
    assign cmd_fire_c    = valid_extract & ready_extract;
    assign in_fire_c     = valid_in & ready_in;
    assign next_res_nz_c = |next_keep_c;

    axis_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .LEN_WD       (LEN_WD)
    ) u_merge (
        .res_data     (res_data),
        .res_keep     (res_keep),
        .data         (data_in),
        .keep         (keep_in),
        .hdr_len      (hdr_len),
        .shr_data_c   (shr_data_c),
        .shr_keep_c   (shr_keep_c),
        .merge_data_c (merge_data_c),
        .merge_keep_c (merge_keep_c),
        .next_data_c  (next_data_c),
        .next_keep_c  (next_keep_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_fire_c) state_nxt = HEAD;
            HEAD:  if (in_fire_c) begin
                       if (!last_in)           state_nxt = BODY;
                       else if (next_res_nz_c) state_nxt = FLUSH;
                       else                    state_nxt = IDLE;
                   end
            BODY:  if (in_fire_c && last_in) state_nxt = next_res_nz_c ? FLUSH : IDLE;
            FLUSH: if (out_free_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_extract = 1'b0;
        ready_in      = 1'b0;
        case (state)
            IDLE:    ready_extract = 1'b1;
            HEAD:    ready_in      = hdr_free_c & out_free_c;
            BODY:    ready_in      = out_free_c;
            default: ready_in      = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          hdr_len <= '0;
        else if (cmd_fire_c) hdr_len <= LEN_WD'(byte_extract_cnt) + LEN_WD'(1);
    end

    // Header register: loaded from the first beat, drains independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
            err_header   <= 1'b0;
`endif
        end else if (in_fire_c && state == HEAD) begin
            valid_header <= 1'b1;
            data_header  <= shr_data_c;
            keep_header  <= shr_keep_c;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
            err_header   <= popcount(MAX_BYTE_WD'(shr_keep_c)) < 32'(hdr_len);
`endif
        end else if (ready_header) begin
            valid_header <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (in_fire_c && state == BODY) begin
            valid_out <= 1'b1;
            data_out  <= merge_data_c;
            keep_out  <= merge_keep_c;
            last_out  <= last_in & ~next_res_nz_c;
        end else if (state == FLUSH && out_free_c) begin
            valid_out <= 1'b1;
            data_out  <= res_data;
            keep_out  <= res_keep;
            last_out  <= 1'b1;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    // Residual holds the tail bytes of the last accepted beat awaiting the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_keep <= '0;
        end else if (in_fire_c) begin
            res_data <= next_data_c;
            res_keep <= next_keep_c;
        end else if (state == FLUSH && out_free_c) begin
            res_data <= '0;
            res_keep <= '0;
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench for axi_stream_extract_header: byte-level reference model,
// directed scenarios plus randomized packets and backpressure.
module tb_axi_stream_extract_header;

    localparam int unsigned W      = 4;
    localparam int          BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_extract = 1'b0;
    logic [1:0]  byte_extract_cnt = '0;
    logic        ready_extract;
    logic        valid_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic        err_header;
    logic        ready_header = 1'b1;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .data_in          (data_in),
        .keep_in          (keep_in),
        .last_in          (last_in),
        .ready_in         (ready_in),
        .valid_extract    (valid_extract),
        .byte_extract_cnt (byte_extract_cnt),
        .ready_extract    (ready_extract),
        .valid_header     (valid_header),
        .data_header      (data_header),
        .keep_header      (keep_header),
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
        .err_header       (err_header),
`endif
        .ready_header     (ready_header),
        .valid_out        (valid_out),
        .data_out         (data_out),
        .keep_out         (keep_out),
        .last_out         (last_out),
        .ready_out        (ready_out)
    );

`ifndef AXIS_EXTRACT_SHORT_ERR_EN
    assign err_header = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [3:0] k; logic f; } exp_t;

    exp_t        exp_hdr[$];
    exp_t        exp_out[$];
    logic [7:0]  pkt_bytes[$];
    int          errors = 0;
    int          checks = 0;
    bit          sb_on = 1'b1;
    int          rdy_mode = 0;
    int          out_hold = 0;
    int          hdr_hold = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: header is the first H packet bytes right-aligned (only those present
    // in the first beat); payload is the remaining bytes repacked MSB-first.
    task automatic push_expect(input int h);
        exp_t e;
        int   n, fb;
        n  = pkt_bytes.size();
        fb = (n < int'(W)) ? n : int'(W);
        e.d = '0; e.k = '0;
        for (int i = 0; i < h; i++) begin
            if (i < fb) begin
                e.d[8*(h-1-i) +: 8] = pkt_bytes[i];
                e.k[h-1-i] = 1'b1;
            end
        end
        e.f = (fb < h);
        exp_hdr.push_back(e);
        for (int p = h; p < n; p += int'(W)) begin
            e.d = '0; e.k = '0;
            for (int j = 0; j < int'(W); j++) begin
                if (p + j < n) begin
                    e.d[8*(int'(W)-1-j) +: 8] = pkt_bytes[p+j];
                    e.k[int'(W)-1-j] = 1'b1;
                end
            end
            e.f = (p + int'(W) >= n);
            exp_out.push_back(e);
        end
    endtask

    task automatic send_cmd(input int h);
        int cnt;
        bit fire;
        valid_extract = 1'b1;
        byte_extract_cnt = 2'(h - 1);
        cnt = 0; fire = 1'b0;
        while (!fire && cnt < BUDGET) begin
            @(negedge clk); fire = ready_extract;
            @(posedge clk); #1; cnt++;
        end
        valid_extract = 1'b0;
        if (!fire) check("cmd_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_beat(input int b);
        logic [31:0] d;
        logic [3:0]  k;
        int n, idx, cnt;
        bit fire;
        n = pkt_bytes.size();
        d = $urandom; k = '0;
        for (int j = 0; j < int'(W); j++) begin
            idx = b * int'(W) + j;
            if (idx < n) begin
                d[8*(int'(W)-1-j) +: 8] = pkt_bytes[idx];
                k[int'(W)-1-j] = 1'b1;
            end
        end
        data_in = d; keep_in = k;
        last_in = (b * int'(W) + int'(W) >= n);
        valid_in = 1'b1;
        cnt = 0; fire = 1'b0;
        while (!fire && cnt < BUDGET) begin
            @(negedge clk); fire = ready_in;
            @(posedge clk); #1; cnt++;
        end
        valid_in = 1'b0; last_in = 1'b0;
        if (!fire) check("in_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_beats(input int h);
        send_cmd(h);
        for (int b = 0; b < (pkt_bytes.size() + int'(W) - 1) / int'(W); b++) send_beat(b);
    endtask

    task automatic run_packet(input int h);
        push_expect(h);
        send_beats(h);
    endtask

    task automatic set_pkt(input logic [95:0] words, input int n);
        pkt_bytes.delete();
        for (int i = 0; i < n; i++) pkt_bytes.push_back(words[95-8*i -: 8]);
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((exp_hdr.size() != 0 || exp_out.size() != 0) && cnt < BUDGET) begin
            @(posedge clk); #1; cnt++;
        end
    endtask

    // Ready generator: always ready, random, or scripted hold counters.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: begin ready_out = 1'b1; ready_header = 1'b1; end
            1: begin
                ready_out    = ($urandom_range(0, 3) != 0);
                ready_header = ($urandom_range(0, 2) != 0);
            end
            default: begin
                ready_out    = (out_hold == 0);
                ready_header = (hdr_hold == 0);
                if (out_hold != 0) out_hold--;
                if (hdr_hold != 0) hdr_hold--;
            end
        endcase
    end

    bit          pv_o, pv_h;
    logic [36:0] ps_o, ps_h;

    // Monitor: handshakes pop the scoreboard; stalled outputs must stay put.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pv_o = 1'b0; pv_h = 1'b0;
        end else begin
            if (pv_o) check("out_hold", {valid_out, data_out, keep_out, last_out}, {1'b1, ps_o});
            if (pv_h) check("hdr_hold", {valid_header, data_header, keep_header, err_header}, {1'b1, ps_h});
            if (valid_out && !ready_out) check("ready_in_bp", 64'(ready_in), 64'd0);
            if (valid_out && ready_out && sb_on) begin
                if (exp_out.size() == 0) check("out_extra", {data_out, keep_out, last_out}, 64'd0);
                else begin
                    e = exp_out.pop_front();
                    check("payload", {data_out, keep_out, last_out}, {e.d, e.k, e.f});
                end
            end
            if (valid_header && ready_header && sb_on) begin
                if (exp_hdr.size() == 0) check("hdr_extra", {data_header, keep_header}, 64'd0);
                else begin
                    e = exp_hdr.pop_front();
                    check("header", {data_header, keep_header}, {e.d, e.k});
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
                    check("err_header", 64'(err_header), 64'(e.f));
`endif
                end
            end
            pv_o = valid_out && !ready_out;
            ps_o = {data_out, keep_out, last_out};
            pv_h = valid_header && !ready_header;
            ps_h = {data_header, keep_header, err_header};
        end
    end

    initial begin
        int n, cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_valid_header", 64'(valid_header), 64'd0);
        check("rst_ready_extract", 64'(ready_extract), 64'd1);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        check("rst_out_regs", {data_out, keep_out, last_out}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        set_pkt(96'hAABBCCDD_EEFF0011_22330000, 10); run_packet(2);
        set_pkt(96'hAABBCCDD_EEFF0011_22334400, 11); run_packet(1);
        set_pkt(96'hAABBCCDD_00000000_00000000, 4);  run_packet(4);
        set_pkt(96'hAABB0000_00000000_00000000, 2);  run_packet(3);
        drain();

        // Scripted backpressure on both channels mid-packet.
        rdy_mode = 2; out_hold = 1000; hdr_hold = 1000;
        set_pkt(96'hAABBCCDD_EEFF0011_22330000, 10); push_expect(2);
        fork
            send_beats(2);
            begin
                cnt = 0;
                while (!valid_header && cnt < 200) begin @(negedge clk); cnt++; end
                hdr_hold = 3;
                check("bp_hdr_seen", 64'(valid_header), 64'd1);
                cnt = 0;
                while (!valid_out && cnt < 200) begin @(negedge clk); cnt++; end
                out_hold = 5;
                check("bp_out_seen", 64'(valid_out), 64'd1);
            end
        join
        drain();

        // Reset during BODY with both outputs stalled and valid.
        sb_on = 1'b0; out_hold = 1000; hdr_hold = 1000;
        set_pkt(96'h01020304_05060708_090A0B0C, 12);
        send_cmd(2); send_beat(0); send_beat(1);
        cnt = 0;
        while (!(valid_out && valid_header) && cnt < 50) begin @(negedge clk); cnt++; end
        check("pre_rst_valids", {valid_out, valid_header}, 64'd3);
        #2 rst_n = 1'b0;
        #1 check("rst_drop_valids", {valid_out, valid_header}, 64'd0);
        @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
        out_hold = 0; hdr_hold = 0;
        #1 check("post_rst_ready", {ready_extract, ready_in}, 64'd2);
        @(posedge clk); #1 sb_on = 1'b1; rdy_mode = 0;
        set_pkt(96'hAABBCCDD_EEFF0011_22330000, 10); run_packet(2);
        drain();

        for (int p = 0; p < 300; p++) begin
            rdy_mode = ((p / 50) % 2 == 0) ? 1 : 0;
            n = $urandom_range(1, 14);
            pkt_bytes.delete();
            for (int i = 0; i < n; i++) pkt_bytes.push_back(8'($urandom));
            run_packet($urandom_range(1, 4));
        end
        rdy_mode = 0;
        drain();
        repeat (4) @(posedge clk);
        check("hdr_queue_empty", 64'(exp_hdr.size()), 64'd0);
        check("out_queue_empty", 64'(exp_out.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
